mux4_rr_arbiter: RTL and testbench

MUX4_RR_ARBITER -- requirements
Module: mux4_rr_arbiter

---
 rtl/mux4_rr_arbiter.sv | 90 +++++++++
 tb/tb_mux4_rr_arbiter.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/mux4_rr_arbiter.sv
// mux4_rr_arbiter: 4-requester round-robin arbiter driving a registered-select 4:1 data mux
//   clk, rst        clock and asynchronous active-high reset
//   req[3:0]        per-requester request
//   i0..i3 [W-1:0]  requester data
//   gnt[3:0]        one-hot grant, zero when no grant is held
//   s1, s0          registered select code of the granted requester
//   f [W-1:0]       data selected by {s1,s0}
//   f_valid/f_ready output handshake
//   busy            grant held
//   err             one-cycle watchdog abort pulse (only with MUX_ARB_WDOG_EN defined)
module mux4_rr_arbiter #(
  parameter int W = 8,
  parameter int TIMEOUT = 15
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [3:0]   req,
  input  logic [W-1:0] i0,
  input  logic [W-1:0] i1,
  input  logic [W-1:0] i2,
  input  logic [W-1:0] i3,
  output logic [3:0]   gnt,
  output logic         s1,
  output logic         s0,
  output logic [W-1:0] f,
  output logic         f_valid,
  input  logic         f_ready,
  output logic         busy,
  output logic         err
);
  typedef enum logic {IDLE, XFER} state_t;
  state_t state, state_n;
  logic [1:0] ptr, ptr_n, sel, sel_n, nxt, off;
  logic [3:0] rot;
  logic done, wd_hit;
  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
    $error("TIMEOUT must be in 1..255");
  end
  // rot[j] is the request of requester ptr+1+j, so the first set bit is the winner
  assign nxt = ptr + 2'd1;
  assign rot = 4'({req, req} >> nxt);
  assign off = rot[0] ? 2'd0 : rot[1] ? 2'd1 : rot[2] ? 2'd2 : 2'd3;
  assign busy = state == XFER;
  assign gnt = busy ? 4'b1 << sel : 4'b0;
  assign {s1, s0} = sel;
  assign f_valid = busy && req[sel];
  assign f = sel == 2'd0 ? i0 : sel == 2'd1 ? i1 : sel == 2'd2 ? i2 : i3;
  // a held grant ends on transfer, on the requester dropping req, or on watchdog expiry
  assign done = busy && (!req[sel] || f_ready || wd_hit);
`ifdef MUX_ARB_WDOG_EN
  logic [7:0] cnt;
  logic err_q;
  assign wd_hit = f_valid && !f_ready && cnt == 8'(TIMEOUT - 1);
  assign err = err_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt <= 8'd0;
      err_q <= 1'b0;
    end else begin
      cnt <= (f_valid && !f_ready && !wd_hit) ? cnt + 8'd1 : 8'd0;
      err_q <= wd_hit;
    end
`else
  assign wd_hit = 1'b0;
  assign err = 1'b0;
`endif
  always_comb begin
    state_n = state;
    ptr_n = ptr;
    sel_n = sel;
    if (state == IDLE && |req) begin
      sel_n = nxt + off;
      state_n = XFER;
    end
    if (done) begin
      ptr_n = sel;
      state_n = IDLE;
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      ptr <= 2'd3;
      sel <= 2'd0;
    end else begin
      state <= state_n;
      ptr <= ptr_n;
      sel <= sel_n;
    end
endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// tb_mux4_rr_arbiter: scoreboard bench for mux4_rr_arbiter
module tb_mux4_rr_arbiter;
  localparam int W = 8;
`ifdef MUX_ARB_WDOG_EN
  localparam int STALLS = 3;
`else
  localparam int STALLS = 5;
`endif
  logic clk = 0, rst, f_ready, s1, s0, f_valid, busy, err;
  logic [3:0] req, gnt;
  logic [W-1:0] i0, i1, i2, i3, f;
  logic [W-1:0] ival [4] = '{8'hA5, 8'h5A, 8'h3C, 8'hC3};
  logic [1:0] q [$];
  int tests = 0, fails = 0;
  assign i0 = ival[0];
  assign i1 = ival[1];
  assign i2 = ival[2];
  assign i3 = ival[3];
  mux4_rr_arbiter #(.W(W), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .req(req), .i0(i0), .i1(i1), .i2(i2), .i3(i3),
    .gnt(gnt), .s1(s1), .s0(s0), .f(f), .f_valid(f_valid), .f_ready(f_ready),
    .busy(busy), .err(err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk_reset(input string name);
    chk({name, "_gnt"}, gnt, 0);
    chk({name, "_sel"}, {s1, s0}, 0);
    chk({name, "_fvalid"}, f_valid, 0);
    chk({name, "_busy"}, busy, 0);
    chk({name, "_err"}, err, 0);
  endtask
  always @(negedge clk)
    if (!rst && f_valid && f_ready) begin
      logic [1:0] e;
      chk("xfer_expected", q.size() != 0, 1);
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("xfer_sel", {s1, s0}, e);
        chk("xfer_gnt", gnt, 4'b1 << e);
        chk("xfer_f", f, ival[e]);
      end
    end
  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end
  initial begin
    rst = 1; req = 0; f_ready = 0;
    #2 chk_reset("reset");
    #10 rst = 0;
    // single requester, immediate accept
    req = 4'b0001; f_ready = 1; q.push_back(0);
    step();
    chk("a_gnt", gnt, 4'b0001);
    chk("a_sel", {s1, s0}, 0);
    chk("a_f", f, 8'hA5);
    chk("a_fvalid", f_valid, 1);
    step();
    req = 0;
    chk("a_gnt_after", gnt, 0);
    chk("a_busy_after", busy, 0);
    // all requesting from reset: 0,1,2,3,0 with an idle cycle between grants
    rst = 1; #2 rst = 0;
    req = 4'b1111;
    for (int n = 0; n < 5; n++) q.push_back(2'(n % 4));
    for (int n = 0; n < 5; n++) begin
      step();
      chk("b_gnt", gnt, 4'b1 << (n % 4));
      step();
      chk("b_idle_gnt", gnt, 0);
    end
    req = 0;
    // stalled grant holds data, single transfer on release
    req = 4'b0100; f_ready = 0; q.push_back(2);
    step();
    for (int s = 0; s < STALLS; s++) begin
      chk("c_gnt", gnt, 4'b0100);
      chk("c_f", f, 8'h3C);
      chk("c_fvalid", f_valid, 1);
      step();
    end
    f_ready = 1;
    chk("c_gnt_rel", gnt, 4'b0100);
    step();
    req = 0;
    chk("c_busy_after", busy, 0);
    // drop of granted req with f_ready high aborts; ptr moves to 1 so 2 wins over 0
    req = 4'b0010; f_ready = 0;
    step();
    chk("d_gnt", gnt, 4'b0010);
    req = 4'b0101; f_ready = 1;
    #1 chk("d_fvalid_drop", f_valid, 0);
    step();
    chk("d_busy_abort", busy, 0);
    chk("d_gnt_abort", gnt, 0);
    q.push_back(2);
    step();
    chk("d_gnt_next", gnt, 4'b0100);
    step();
    req = 0;
    // watchdog behaviour
    req = 4'b1000; f_ready = 0;
    step();
    chk("e_gnt", gnt, 4'b1000);
`ifdef MUX_ARB_WDOG_EN
    for (int k = 0; k < 3; k++) begin
      step();
      chk("e_err_early", err, 0);
      chk("e_gnt_hold", gnt, 4'b1000);
    end
    step();
    req = 0;
    chk("e_err_pulse", err, 1);
    chk("e_gnt_abort", gnt, 0);
    step();
    chk("e_err_once", err, 0);
`else
    for (int k = 0; k < 8; k++) begin
      step();
      chk("e_gnt_hold", gnt, 4'b1000);
      chk("e_err", err, 0);
    end
    q.push_back(3); f_ready = 1;
    step();
    req = 0;
    chk("e_gnt_after", gnt, 0);
`endif
    // asynchronous reset mid-transfer, then requester 0 wins first
    f_ready = 0; req = 4'b0100;
    step();
    chk("f_busy", busy, 1);
    #2 rst = 1;
    #1 chk_reset("f_async");
    #2 rst = 0;
    req = 4'b1001; f_ready = 1; q.push_back(0);
    step();
    chk("f_gnt", gnt, 4'b0001);
    chk("f_f", f, 8'hA5);
    step();
    req = 0;
    chk("f_idle", busy, 0);
    chk("queue_empty", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
